// File: rtl/hourglass_sequencer_if.sv
// hourglass_sequencer_if: frame bitmap and update handshake between sequencer and row-scan driver
interface hourglass_sequencer_if;
  logic [2:0] row_sel;
  logic [7:0] row_r;
  logic [7:0] row_g;
  logic       upd_req;
  logic       upd_ack;
  modport master(input row_sel, upd_ack, output row_r, row_g, upd_req);
  modport slave(output row_sel, upd_ack, input row_r, row_g, upd_req);
endinterface

// File: rtl/hourglass_sequencer.sv
// hourglass_sequencer: grain state, run/pause/done FSM and frame serving for the dot-matrix hourglass
// Optional HG_FLIP_SYNC_EN adds a two-flop synchronizer on the tilt switch.
module hourglass_sequencer #(
  parameter int SEC_CYC   = 50_000_000,
  parameter int GRAIN_SEC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       flip,
  hourglass_sequencer_if.master bus,
  output logic [4:0] top_cnt,
  output logic [4:0] bot_cnt,
  output logic [6:0] el_sec,
  output logic [1:0] state,
  output logic       done
);
  localparam int PW = SEC_CYC > 1 ? $clog2(SEC_CYC) : 1;
  localparam int GW = GRAIN_SEC > 1 ? $clog2(GRAIN_SEC) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FIN} state_t;
  state_t cs, ns;
  logic [PW-1:0] ps;
  logic [GW-1:0] gs;
  logic orient, fs, fq, fe, ps_tc, gs_tc, xfer, chg, chg_q, req;
  logic [2:0] lr;
`ifdef HG_FLIP_SYNC_EN
  logic [1:0] sy;
  always_ff @(posedge clk) sy <= !rst ? {2{flip}} : {sy[0], flip};
  assign fs = sy[1];
`else
  assign fs = flip;
`endif
  assign fe    = fs ^ fq;
  assign ps_tc = ps == PW'(SEC_CYC - 1);
  assign gs_tc = gs == GW'(GRAIN_SEC - 1);
  assign xfer  = cs == RUN && ps_tc && gs_tc && top_cnt != 5'd0;
  assign chg   = fe | xfer;
  assign state = cs;
  assign done  = cs == FIN;
  assign bus.upd_req = req;
  always_comb begin
    ns = cs;
    if (fe) ns = cs == FIN ? IDLE : cs;
    else if (xfer && top_cnt == 5'd1) ns = FIN;
    else if (start_stop) ns = (cs == IDLE || cs == PAUSE) ? RUN : cs == RUN ? PAUSE : cs;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs      <= IDLE;
      top_cnt <= 5'd16;
      bot_cnt <= 5'd0;
      orient  <= 1'b0;
      el_sec  <= 7'd0;
      ps      <= '0;
      gs      <= '0;
      fq      <= flip;
      chg_q   <= 1'b0;
      req     <= 1'b0;
    end else begin
      cs    <= ns;
      fq    <= fs;
      chg_q <= chg;
      // a change landing on the ack edge keeps the request alive
      req   <= chg_q | (req & ~(bus.upd_ack & ~chg));
      if (fe) begin
        top_cnt <= bot_cnt;
        bot_cnt <= top_cnt;
        orient  <= ~orient;
        ps      <= '0;
        gs      <= '0;
        el_sec  <= 7'd0;
      end else if (cs == RUN) begin
        ps <= ps_tc ? '0 : ps + 1'b1;
        if (ps_tc) begin
          el_sec <= el_sec + 7'(el_sec != 7'd127);
          gs     <= gs_tc ? '0 : gs + 1'b1;
        end
        if (xfer) begin
          top_cnt <= top_cnt - 5'd1;
          bot_cnt <= bot_cnt + 5'd1;
        end
      end
    end
  end
  assign lr = bus.row_sel ^ {3{orient}};
  // upper cells fill from the neck outward, lower cells pile up from the base
  always_comb begin
    bus.row_r = 8'd0;
    bus.row_g = 8'd0;
    for (int k = 0; k < 4; k++) begin
      bus.row_r[k+2] = ~lr[2] & ({1'b0, lr[1:0], k[1:0]} >= 5'd16 - top_cnt);
      bus.row_g[k+2] = lr[2] & ({1'b0, ~lr[1:0], k[1:0]} < bot_cnt);
    end
  end
endmodule

// File: tb/tb_hourglass_sequencer.sv
// tb_hourglass_sequencer: directed, table-driven check of the hourglass sequencer
module tb_hourglass_sequencer;
`ifdef HG_FLIP_SYNC_EN
  localparam int FL = 3;
`else
  localparam int FL = 1;
`endif
  logic clk = 0, rst = 0, start_stop = 0, flip = 0;
  logic [4:0] top_cnt, bot_cnt;
  logic [6:0] el_sec;
  logic [1:0] state;
  logic done;
  int errs = 0, checks = 0;
  hourglass_sequencer_if bus();
  hourglass_sequencer #(.SEC_CYC(10), .GRAIN_SEC(2)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .flip(flip), .bus(bus),
    .top_cnt(top_cnt), .bot_cnt(bot_cnt), .el_sec(el_sec), .state(state), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {int ph; logic [2:0] rs; logic [7:0] r; logic [7:0] g;} vec_t;
  vec_t tbl[14];
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic pulse_ss();
    start_stop = 1;
    step(1);
    start_stop = 0;
  endtask
  task automatic apply(input int ph);
    for (int i = 0; i < 14; i++)
      if (tbl[i].ph == ph) begin
        bus.row_sel = tbl[i].rs;
        #1;
        chk($sformatf("row_r ph%0d rs%0d", ph, tbl[i].rs), bus.row_r, tbl[i].r);
        chk($sformatf("row_g ph%0d rs%0d", ph, tbl[i].rs), bus.row_g, tbl[i].g);
      end
    bus.row_sel = 0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " state"}, state, 0);
    chk({tag, " top"}, top_cnt, 16);
    chk({tag, " bot"}, bot_cnt, 0);
    chk({tag, " el"}, el_sec, 0);
    chk({tag, " req"}, bus.upd_req, 0);
    chk({tag, " done"}, done, 0);
  endtask
  initial begin
    tbl = '{
      '{0, 3'd0, 8'h3C, 8'h00}, '{0, 3'd3, 8'h3C, 8'h00}, '{0, 3'd4, 8'h00, 8'h00}, '{0, 3'd7, 8'h00, 8'h00},
      '{1, 3'd0, 8'h38, 8'h00}, '{1, 3'd1, 8'h3C, 8'h00}, '{1, 3'd6, 8'h00, 8'h00}, '{1, 3'd7, 8'h00, 8'h04},
      '{2, 3'd0, 8'h00, 8'h00}, '{2, 3'd4, 8'h00, 8'h3C}, '{2, 3'd7, 8'h00, 8'h3C},
      '{3, 3'd0, 8'h00, 8'h00}, '{3, 3'd4, 8'h3C, 8'h00}, '{3, 3'd7, 8'h3C, 8'h00}
    };
    bus.row_sel = 0;
    bus.upd_ack = 0;
    step(2);
    rst = 1;
    chk_reset("reset");
    apply(0);
    pulse_ss();
    chk("run entered", state, 1);
    step(19);
    chk("no early xfer", top_cnt, 16);
    step(1);
    chk("xfer top", top_cnt, 15);
    chk("xfer bot", bot_cnt, 1);
    chk("xfer el", el_sec, 2);
    chk("req lags", bus.upd_req, 0);
    step(1);
    chk("req set", bus.upd_req, 1);
    apply(1);
    rst = 0;
    step(1);
    rst = 1;
    chk_reset("mid-run reset");
    pulse_ss();
    step(14);
    pulse_ss();
    chk("paused", state, 2);
    chk("pause el", el_sec, 1);
    step(50);
    chk("pause frozen top", top_cnt, 16);
    chk("pause frozen el", el_sec, 1);
    pulse_ss();
    chk("resumed", state, 1);
    step(4);
    chk("resume no early xfer", top_cnt, 16);
    step(1);
    chk("resume xfer", top_cnt, 15);
    chk("resume el", el_sec, 2);
    step(299);
    chk("pre-done state", state, 1);
    chk("pre-done top", top_cnt, 1);
    step(1);
    chk("done state", state, 3);
    chk("done flag", done, 1);
    chk("done top", top_cnt, 0);
    chk("done bot", bot_cnt, 16);
    chk("done el", el_sec, 32);
    step(1);
    chk("req held no ack", bus.upd_req, 1);
    bus.upd_ack = 1;
    step(1);
    chk("ack clears", bus.upd_req, 0);
    step(1);
    bus.upd_ack = 0;
    chk("idle ack ignored", bus.upd_req, 0);
    pulse_ss();
    step(25);
    chk("ss in done ignored", state, 3);
    chk("done frozen top", top_cnt, 0);
    apply(2);
    flip = 1;
    step(FL);
    chk("flip state", state, 0);
    chk("flip top", top_cnt, 16);
    chk("flip bot", bot_cnt, 0);
    chk("flip el", el_sec, 0);
    chk("flip done", done, 0);
    apply(3);
    step(1);
    chk("flip req", bus.upd_req, 1);
    flip = 0;
    step(FL - 1);
    start_stop = 1;
    step(1);
    start_stop = 0;
    chk("flip beats ss", state, 0);
    chk("flip2 top", top_cnt, 0);
    chk("flip2 bot", bot_cnt, 16);
    step(3);
    chk("ss stays dropped", state, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hourglass_sequencer.md
# hourglass_sequencer

Sequencing controller for the dot-matrix hourglass. It owns the grain state and the run/pause/done state machine. It turns a start/stop pulse and the tilt (weight-sensor) switch into timed grain transfers between the upper and lower halves of the 8×8 dual-colour matrix. It serves per-row red/green column bitmaps to the row-scan driver, and announces each new frame with a req/ack handshake.

## Interface
- SEC_CYC, 50_000_000: clk cycles per 1 s tick
- GRAIN_SEC, 4: seconds per grain transfer (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- start_stop  in  1  single-cycle, debounced pulse; toggles run/pause
- flip  in  1  tilt-switch level; every edge means the hourglass was inverted
- row_sel  in  3  row index requested by scan driver
- row_r  out  8  red column bits for row_sel, active-high, bit n = column n (combinational)
- row_g  out  8  green column bits for row_sel (combinational)
- upd_req  out  1  new frame available
- upd_ack  in  1  scan driver has latched the frame
- top_cnt  out  5  grains in upper half, 0..16
- bot_cnt  out  5  grains in lower half, 0..16
- el_sec  out  7  elapsed run seconds, saturates at 127
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
- done  out  1  high while state==DONE

## Operation
- Reset values (rst=0 at a clk edge):
  - state=IDLE, top_cnt=16, bot_cnt=0, orient=0, el_sec=0, upd_req=0, done=0
  - prescaler=0, grain-second counter gs=0
  - flip edge-detector history loaded with the current flip value, so there is no spurious edge.
- State machine transitions on start_stop:
  - IDLE→RUN
  - RUN→PAUSE
  - PAUSE→RUN
  - DONE: start_stop ignored.
- RUN:
  - Prescaler counts 0..SEC_CYC-1. At its terminal count: el_sec+1 (saturating), and gs counts 0..GRAIN_SEC-1.
  - When gs wraps, on the same edge: top_cnt-1, bot_cnt+1.
  - If top_cnt becomes 0, state→DONE on that same edge.
- PAUSE: prescaler, gs and el_sec frozen.
- Flip (detected edge):
  - Swap top_cnt and bot_cnt, toggle orient.
  - Clear prescaler, gs and el_sec.
  - If state==DONE, state→IDLE. Otherwise state is unchanged.
  - Flip wins over a same-cycle start_stop; that start_stop is dropped.
- Frame geometry: columns 2..5 only, all other column bits 0.
  - Logical row lr = orient ? 7-row_sel : row_sel.
  - Upper region is lr 0..3, cell i = lr*4+(col-2). Lit red if i ≥ 16-top_cnt.
  - Lower region is lr 4..7, cell j = (7-lr)*4+(col-2). Lit green if j < bot_cnt.
  - row_g=0 in the upper region; row_r=0 in the lower region.
- Handshake:
  - Any edge that changes top_cnt, bot_cnt or orient sets upd_req on the following edge.
  - upd_req stays high until upd_ack is sampled high, then clears on that edge.
  - Changes while a request is pending coalesce into the same request.
  - If a change and upd_ack coincide, upd_req stays high.
  - upd_ack while upd_req=0 is ignored.

## Timing
- start_stop → state change: 1 edge.
- First transfer after IDLE→RUN: SEC_CYC*GRAIN_SEC cycles after RUN is entered.
- Pause/resume preserves the partial prescaler count; no time is lost or gained.
- flip → counter swap: 1 edge after the flip edge is seen (plus synchronizer latency, see Configuration).
- row_r/row_g follow row_sel and the counters combinationally with zero latency.
- Reset mid-operation returns every output to its reset value on the next edge, including dropping a pending upd_req.

## Configuration
- HG_FLIP_SYNC_EN:
  - Defined: flip passes through a two-flop synchronizer before edge detection. Flip-to-swap latency is 3 edges.
  - Undefined: flip is treated as synchronous to clk. Latency is 1 edge.

## Test plan
- Reset, row_sel=0 → state=0, top_cnt=16, bot_cnt=0, row_r=8'b00111100, row_g=0, upd_req=0.
- SEC_CYC=10, GRAIN_SEC=2; start_stop pulse; wait 20 cycles:
  - top_cnt=15, bot_cnt=1, el_sec=2, upd_req=1 one cycle later.
  - row_sel=0 → row_r=8'b00111000; row_sel=7 → row_g=8'b00000100.
- Pause at cycle 15 of RUN, hold 50 cycles, resume → first transfer occurs 5 cycles after resume.
- Run uninterrupted 320 cycles → state=DONE, done=1, top_cnt=0, bot_cnt=16, el_sec=32; further start_stop pulses are ignored.
- Flip in DONE → top_cnt=16, bot_cnt=0, state=IDLE, el_sec=0; row_sel=7 → row_r=8'b00111100. Simultaneous flip+start_stop leaves state=IDLE.
- Hold upd_ack=0 across three transfers → upd_req stays 1; one ack clears it. Assert rst mid-RUN → all outputs return to reset values.
